control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Multi-cycle sequencer for the 16-bit CPU. It sits directly upstream of the register bank.
- Fetches instructions at the current PC over a req/ack handshake and decodes them.
- Drives the bank's read selects (src_reg, dst_reg), its write port (wr_reg, wr_en) and its PC update (pc_inc, pc_data_in).
- Selects the write-back source and holds the Z status flag.

Parameters:
- PC_REG, 0, register index holding the PC. Must match the bank's pc index.
- PC_STEP, 2, byte increment per instruction.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- pc_data_out  in  16  current PC from the register bank
- imem_req  out  1  instruction fetch request
- imem_addr  out  16  fetch address; equals pc_data_out
- imem_ack  in  1  instruction valid this cycle
- imem_data  in  16  instruction word
- alu_zero  in  1  ALU result == 0, valid in EXEC
- src_reg  out  4  read select A
- dst_reg  out  4  read select B
- wr_reg  out  4  write select
- wr_en  out  1  register write strobe
- wr_sel  out  2  wr_data mux: 0=ALU, 1=operand A (MOV), 2=status
- alu_op  out  3  0=pass, 1=add, 2=sub, 3=and, 4=xor
- pc_inc  out  1  PC write strobe
- pc_data_in  out  16  next PC value
- halted  out  1  core stopped
- stat_z  out  1  zero flag

Behaviour:
- Instruction format: [15:12] opcode, [11:8] src, [7:4] dst, [7:0] off8 (jumps only).
- Opcodes:
  - 0 NOP
  - 1 MOV: dst<=src
  - 2 ADD: dst<=dst+src
  - 3 SUB: dst<=dst-src
  - 4 AND
  - 5 XOR
  - 6 JMP
  - 7 JZ
  - F HALT
  - 8-E are executed as NOP.
- States: FETCH -> DECODE -> EXEC -> WB -> FETCH. HALT is a sink.
- FETCH:
  - imem_req=1 and imem_addr=pc_data_out.
  - On the cycle imem_ack=1, latch imem_data into the instruction register and go to DECODE.
  - Otherwise stay in FETCH with req held high.
- DECODE (1 cycle): src_reg and dst_reg are driven from the instruction register. They stay stable through WB.
- EXEC (1 cycle): alu_op is driven. alu_zero is sampled at the end of EXEC into a temporary.
- WB (1 cycle):
  - ALU ops (2-5): wr_en=1, wr_reg=dst, wr_sel=0, and stat_z updates from the sampled alu_zero.
  - MOV: wr_en=1, wr_sel=1. stat_z is unchanged.
  - All opcodes: pc_inc=1 with pc_data_in = pc+PC_STEP, 16-bit wrap (0xFFFE -> 0x0000).
  - JMP: pc_data_in = pc + PC_STEP + (sext(off8) << 1), mod 2^16.
  - JZ: same target as JMP when stat_z=1, otherwise pc+PC_STEP.
  - HALT: no pc_inc. Go to HALT, where halted=1 and every strobe is 0 until reset.
- Write to PC: if MOV or an ALU op has dst==PC_REG, pc_inc is suppressed in WB. The register write becomes the new PC; the bank would otherwise let pc_inc override it.
- Strobes: wr_en and pc_inc are single-cycle pulses, asserted only in WB. imem_req is asserted only in FETCH.
- Latency: 4 cycles per instruction with zero-wait ack (ack in the first FETCH cycle).
- Reset (rst=0), asynchronous:
  - state=FETCH, instruction register=0 (NOP), stat_z=0, halted=0.
  - All outputs 0: imem_req, wr_en, pc_inc, wr_sel, alu_op, src_reg, dst_reg, wr_reg, pc_data_in.
  - imem_addr still follows pc_data_out.
- Reset mid-fetch or mid-instruction: the instruction is abandoned with no write. imem_req rises in the first cycle after rst releases.
- An imem_ack outside FETCH is ignored.

Test Plan:
- Reset release with pc_data_out=0x0000 and ack tied to 1 -> imem_req=1 in cycle 1. Instruction 0x2120 (ADD r2,r1): wr_en pulses in cycle 4 with wr_reg=2, alu_op=1, and pc_inc with pc_data_in=0x0002.
- Fetch wait: ack arrives 3 cycles late -> imem_req is held for 4 cycles and imem_addr is stable. WB occurs 3 cycles later than the zero-wait case. No strobe fires during the wait.
- JZ with stat_z=1 at pc=0x0010 and off8=0xFC -> pc_data_in=0x000A. Same instruction with stat_z=0 -> pc_data_in=0x0012.
- MOV r0,r5 (0x1500) -> wr_en=1, wr_reg=0, wr_sel=1 and pc_inc=0 in WB. Wrap case: NOP at pc=0xFFFE -> pc_data_in=0x0000.
- SUB with alu_zero=1 -> stat_z=1 after WB. A following MOV leaves stat_z=1. HALT (0xF000) -> halted=1 and no further imem_req for 20 cycles.
- Assert rst low during EXEC of an ADD -> no wr_en and no pc_inc pulse. All outputs read 0 immediately (asynchronous). Fetching restarts after release.

Source files
------------

// File: rtl/control_unit.sv
// Multi-cycle sequencer for the 16-bit CPU: fetches over req/ack, decodes, and
// drives the register bank's selects, write port, PC update and the Z flag.
`default_nettype none

module control_unit #(
  parameter int PC_REG  = 0,
  parameter int PC_STEP = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc_data_out,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  input  logic        alu_zero,
  output logic [3:0]  src_reg,
  output logic [3:0]  dst_reg,
  output logic [3:0]  wr_reg,
  output logic        wr_en,
  output logic [1:0]  wr_sel,
  output logic [2:0]  alu_op,
  output logic        pc_inc,
  output logic [15:0] pc_data_in,
  output logic        halted,
  output logic        stat_z
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_JZ   = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;

  // wr_sel encodings; 2 (status) is reserved for the bank's mux.
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MOV = 2'd1;

  state_t      r_state;
  logic [15:0] r_ir;
  logic        r_zero_tmp;

  logic [3:0]  w_opcode;
  logic        w_is_alu;
  logic        w_is_mov;
  logic        w_writes;
  logic        w_dst_is_pc;
  logic        w_take_jump;
  logic [15:0] w_off;
  logic [15:0] w_pc_seq;
  logic [15:0] w_pc_jmp;
  logic [2:0]  w_alu_op;

  assign imem_addr   = pc_data_out;
  assign w_opcode    = r_ir[15:12];
  assign w_is_alu    = (w_opcode >= OP_ADD) && (w_opcode <= OP_XOR);
  assign w_is_mov    = (w_opcode == OP_MOV);
  assign w_writes    = w_is_alu || w_is_mov;
  assign w_dst_is_pc = (r_ir[7:4] == 4'(PC_REG));
  assign w_take_jump = (w_opcode == OP_JMP) || ((w_opcode == OP_JZ) && stat_z);
  // Signed word offset: sext(off8) << 1 fills exactly 16 bits.
  assign w_off       = {{7{r_ir[7]}}, r_ir[7:0], 1'b0};
  assign w_pc_seq    = pc_data_out + 16'(PC_STEP);
  assign w_pc_jmp    = w_pc_seq + w_off;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_alu_op = ALU_PASS;
    case (w_opcode)
      OP_ADD:  w_alu_op = ALU_ADD;
      OP_SUB:  w_alu_op = ALU_SUB;
      OP_AND:  w_alu_op = ALU_AND;
      OP_XOR:  w_alu_op = ALU_XOR;
      default: w_alu_op = ALU_PASS;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_FETCH;
      r_ir       <= '0;
      r_zero_tmp <= 1'b0;
      imem_req   <= 1'b0;
      src_reg    <= '0;
      dst_reg    <= '0;
      wr_reg     <= '0;
      wr_en      <= 1'b0;
      wr_sel     <= '0;
      alu_op     <= '0;
      pc_inc     <= 1'b0;
      pc_data_in <= '0;
      halted     <= 1'b0;
      stat_z     <= 1'b0;
    end else begin
      imem_req <= 1'b0;
      wr_en    <= 1'b0;
      pc_inc   <= 1'b0;
      case (r_state)
        S_FETCH: begin
          // An ack only counts while the request is actually on the bus.
          if (imem_req && imem_ack) begin
            r_ir    <= imem_data;
            src_reg <= imem_data[11:8];
            dst_reg <= imem_data[7:4];
            r_state <= S_DECODE;
          end else begin
            imem_req <= 1'b1;
          end
        end
        S_DECODE: begin
          alu_op  <= w_alu_op;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_zero_tmp <= alu_zero;
          r_state    <= S_WB;
          if (w_writes) begin
            wr_en  <= 1'b1;
            wr_reg <= r_ir[7:4];
            wr_sel <= w_is_mov ? WB_MOV : WB_ALU;
          end
          // A register write to the PC is the new PC; pc_inc would override it in the bank.
          if (w_opcode != OP_HALT) begin
            pc_inc     <= !(w_writes && w_dst_is_pc);
            pc_data_in <= w_take_jump ? w_pc_jmp : w_pc_seq;
          end
        end
        S_WB: begin
          if (w_is_alu) stat_z <= r_zero_tmp;
          alu_op <= ALU_PASS;
          wr_reg <= '0;
          wr_sel <= WB_ALU;
          if (w_opcode == OP_HALT) begin
            halted  <= 1'b1;
            r_state <= S_HALT;
          end else begin
            imem_req <= 1'b1;
            r_state  <= S_FETCH;
          end
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// Directed testbench for control_unit: drives fetches by hand and compares the
// bank-facing strobes against hand-computed values.
`timescale 1ns/1ps

module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_data_out;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        alu_zero;
  logic [3:0]  src_reg, dst_reg, wr_reg;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [2:0]  alu_op;
  logic        pc_inc;
  logic [15:0] pc_data_in;
  logic        halted;
  logic        stat_z;

  int n_checks = 0;
  int n_fail   = 0;

  // Values captured by run_instr for the scenario tasks to compare.
  int          cap_fetch_n, cap_wb_cycle;
  logic        cap_addr_bad, cap_strobe_bad;
  logic [3:0]  cap_src, cap_dst, cap_wr_reg;
  logic [2:0]  cap_exec_op, cap_wb_op;
  logic        cap_wr_en, cap_pc_inc;
  logic [1:0]  cap_wr_sel;
  logic [15:0] cap_pc_in;
  logic        cap_post_req, cap_post_z, cap_post_halt, cap_post_strobe;

  always #5 clk = ~clk;

  control_unit #(.PC_REG(0), .PC_STEP(2)) dut (
    .clk(clk), .rst(rst), .pc_data_out(pc_data_out),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .alu_zero(alu_zero), .src_reg(src_reg), .dst_reg(dst_reg), .wr_reg(wr_reg),
    .wr_en(wr_en), .wr_sel(wr_sel), .alu_op(alu_op), .pc_inc(pc_inc),
    .pc_data_in(pc_data_in), .halted(halted), .stat_z(stat_z)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts in a FETCH cycle; acks after wait_n stalled cycles, runs to WB, then one cycle past.
  task automatic run_instr(input logic [15:0] instr, input logic [15:0] pc,
                           input logic zero, input int wait_n);
    int cyc = 0;
    cap_fetch_n = 0; cap_addr_bad = 1'b0; cap_strobe_bad = 1'b0;
    pc_data_out = pc; imem_data = instr; alu_zero = zero;
    for (int k = 0; k <= wait_n; k++) begin
      imem_ack = (k == wait_n);
      cyc++;
      if (imem_req === 1'b1) cap_fetch_n++;
      if (imem_addr !== pc) cap_addr_bad = 1'b1;
      if (wr_en !== 1'b0 || pc_inc !== 1'b0) cap_strobe_bad = 1'b1;
      step();
    end
    imem_ack = 1'b0;
    cyc++;
    cap_src = src_reg; cap_dst = dst_reg;
    if (wr_en !== 1'b0 || pc_inc !== 1'b0 || imem_req !== 1'b0) cap_strobe_bad = 1'b1;
    step();
    cyc++;
    cap_exec_op = alu_op;
    if (wr_en !== 1'b0 || pc_inc !== 1'b0 || imem_req !== 1'b0) cap_strobe_bad = 1'b1;
    step();
    cyc++;
    cap_wb_cycle = cyc;
    cap_wr_en = wr_en; cap_wr_reg = wr_reg; cap_wr_sel = wr_sel;
    cap_wb_op = alu_op; cap_pc_inc = pc_inc; cap_pc_in = pc_data_in;
    step();
    cap_post_req = imem_req; cap_post_z = stat_z; cap_post_halt = halted;
    cap_post_strobe = wr_en | pc_inc;
  endtask

  task automatic test_reset();
    rst = 1'b0; imem_ack = 1'b1; imem_data = 16'h2120; alu_zero = 1'b0; pc_data_out = 16'h1234;
    step(); step();
    n_checks++; if ({imem_req, wr_en, pc_inc, halted, stat_z} !== 5'b0) begin n_fail++; $display("FAIL reset_flags got=%b exp=00000", {imem_req, wr_en, pc_inc, halted, stat_z}); end
    n_checks++; if ({wr_sel, alu_op, src_reg, dst_reg, wr_reg, pc_data_in} !== 33'b0) begin n_fail++; $display("FAIL reset_fields got=%h exp=0", {wr_sel, alu_op, src_reg, dst_reg, wr_reg, pc_data_in}); end
    n_checks++; if (imem_addr !== 16'h1234) begin n_fail++; $display("FAIL reset_addr got=%h exp=1234", imem_addr); end
    pc_data_out = 16'h0000;
    rst = 1'b1;
    step();
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL req_cycle1 got=%b exp=1", imem_req); end
  endtask

  task automatic test_add();
    run_instr(16'h2120, 16'h0000, 1'b0, 0);
    n_checks++; if (cap_fetch_n !== 1 || cap_wb_cycle !== 4) begin n_fail++; $display("FAIL add_latency fetch=%0d wb=%0d exp=1,4", cap_fetch_n, cap_wb_cycle); end
    n_checks++; if (cap_src !== 4'd1 || cap_dst !== 4'd2) begin n_fail++; $display("FAIL add_selects got=%0d,%0d exp=1,2", cap_src, cap_dst); end
    n_checks++; if (cap_exec_op !== 3'd1 || cap_wb_op !== 3'd1) begin n_fail++; $display("FAIL add_alu_op got=%0d,%0d exp=1,1", cap_exec_op, cap_wb_op); end
    n_checks++; if ({cap_wr_en, cap_wr_reg, cap_wr_sel} !== {1'b1, 4'd2, 2'd0}) begin n_fail++; $display("FAIL add_write got=%b/%0d/%0d exp=1/2/0", cap_wr_en, cap_wr_reg, cap_wr_sel); end
    n_checks++; if (cap_pc_inc !== 1'b1 || cap_pc_in !== 16'h0002) begin n_fail++; $display("FAIL add_pc got=%b/%h exp=1/0002", cap_pc_inc, cap_pc_in); end
    n_checks++; if (cap_strobe_bad !== 1'b0 || cap_post_strobe !== 1'b0 || cap_post_req !== 1'b1) begin n_fail++; $display("FAIL add_pulses bad=%b post=%b req=%b exp=0,0,1", cap_strobe_bad, cap_post_strobe, cap_post_req); end
    n_checks++; if (cap_post_z !== 1'b0) begin n_fail++; $display("FAIL add_z got=%b exp=0", cap_post_z); end
  endtask

  task automatic test_fetch_wait();
    run_instr(16'h3340, 16'h0002, 1'b0, 3);
    n_checks++; if (cap_fetch_n !== 4 || cap_addr_bad !== 1'b0) begin n_fail++; $display("FAIL wait_req fetch=%0d addr_bad=%b exp=4,0", cap_fetch_n, cap_addr_bad); end
    n_checks++; if (cap_wb_cycle !== 7 || cap_strobe_bad !== 1'b0) begin n_fail++; $display("FAIL wait_timing wb=%0d bad=%b exp=7,0", cap_wb_cycle, cap_strobe_bad); end
    n_checks++; if (cap_wr_en !== 1'b1 || cap_wb_op !== 3'd2 || cap_pc_in !== 16'h0004) begin n_fail++; $display("FAIL wait_sub got=%b/%0d/%h exp=1/2/0004", cap_wr_en, cap_wb_op, cap_pc_in); end
  endtask

  task automatic test_jumps();
    run_instr(16'h3120, 16'h0020, 1'b1, 0);
    n_checks++; if (cap_post_z !== 1'b1) begin n_fail++; $display("FAIL sub_sets_z got=%b exp=1", cap_post_z); end
    run_instr(16'h70FC, 16'h0010, 1'b0, 0);
    n_checks++; if (cap_pc_inc !== 1'b1 || cap_pc_in !== 16'h000A || cap_wr_en !== 1'b0) begin n_fail++; $display("FAIL jz_taken got=%b/%h/%b exp=1/000a/0", cap_pc_inc, cap_pc_in, cap_wr_en); end
    run_instr(16'h2120, 16'h0040, 1'b0, 0);
    n_checks++; if (cap_post_z !== 1'b0) begin n_fail++; $display("FAIL add_clears_z got=%b exp=0", cap_post_z); end
    run_instr(16'h70FC, 16'h0010, 1'b1, 0);
    n_checks++; if (cap_pc_in !== 16'h0012) begin n_fail++; $display("FAIL jz_not_taken got=%h exp=0012", cap_pc_in); end
    run_instr(16'h6005, 16'h0100, 1'b0, 0);
    n_checks++; if (cap_pc_inc !== 1'b1 || cap_pc_in !== 16'h010C) begin n_fail++; $display("FAIL jmp_fwd got=%b/%h exp=1/010c", cap_pc_inc, cap_pc_in); end
  endtask

  task automatic test_mov_and_wrap();
    run_instr(16'h3120, 16'h0050, 1'b1, 0);
    run_instr(16'h1500, 16'h0052, 1'b0, 0);
    n_checks++; if ({cap_wr_en, cap_wr_reg, cap_wr_sel, cap_pc_inc} !== {1'b1, 4'd0, 2'd1, 1'b0}) begin n_fail++; $display("FAIL mov_pc got=%b/%0d/%0d/%b exp=1/0/1/0", cap_wr_en, cap_wr_reg, cap_wr_sel, cap_pc_inc); end
    n_checks++; if (cap_src !== 4'd5 || cap_post_z !== 1'b1) begin n_fail++; $display("FAIL mov_keeps_z src=%0d z=%b exp=5,1", cap_src, cap_post_z); end
    run_instr(16'h2300, 16'h0060, 1'b0, 0);
    n_checks++; if (cap_wr_en !== 1'b1 || cap_wr_reg !== 4'd0 || cap_pc_inc !== 1'b0) begin n_fail++; $display("FAIL add_to_pc got=%b/%0d/%b exp=1/0/0", cap_wr_en, cap_wr_reg, cap_pc_inc); end
    run_instr(16'h0000, 16'hFFFE, 1'b0, 0);
    n_checks++; if (cap_pc_inc !== 1'b1 || cap_pc_in !== 16'h0000 || cap_wr_en !== 1'b0) begin n_fail++; $display("FAIL nop_wrap got=%b/%h/%b exp=1/0000/0", cap_pc_inc, cap_pc_in, cap_wr_en); end
    run_instr(16'h9123, 16'h0030, 1'b1, 0);
    n_checks++; if (cap_wr_en !== 1'b0 || cap_wb_op !== 3'd0 || cap_pc_in !== 16'h0032 || cap_post_z !== 1'b0) begin n_fail++; $display("FAIL op9_nop got=%b/%0d/%h/%b exp=0/0/0032/0", cap_wr_en, cap_wb_op, cap_pc_in, cap_post_z); end
  endtask

  task automatic test_halt();
    int req_seen = 0;
    int strobe_seen = 0;
    run_instr(16'hF000, 16'h0070, 1'b0, 0);
    n_checks++; if (cap_pc_inc !== 1'b0 || cap_wr_en !== 1'b0) begin n_fail++; $display("FAIL halt_wb got=%b/%b exp=0/0", cap_pc_inc, cap_wr_en); end
    n_checks++; if (cap_post_halt !== 1'b1 || cap_post_req !== 1'b0) begin n_fail++; $display("FAIL halt_state halted=%b req=%b exp=1,0", cap_post_halt, cap_post_req); end
    imem_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (imem_req !== 1'b0) req_seen++;
      if (wr_en !== 1'b0 || pc_inc !== 1'b0) strobe_seen++;
    end
    imem_ack = 1'b0;
    n_checks++; if (req_seen !== 0 || strobe_seen !== 0 || halted !== 1'b1) begin n_fail++; $display("FAIL halt_sink req=%0d strobes=%0d halted=%b exp=0,0,1", req_seen, strobe_seen, halted); end
  endtask

  task automatic test_reset_in_exec();
    int strobe_seen = 0;
    rst = 1'b0; step(); rst = 1'b1;
    step();
    n_checks++; if (imem_req !== 1'b1 || halted !== 1'b0) begin n_fail++; $display("FAIL restart_after_halt req=%b halted=%b exp=1,0", imem_req, halted); end
    pc_data_out = 16'h0080; imem_data = 16'h2120; imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    step();
    n_checks++; if (alu_op !== 3'd1) begin n_fail++; $display("FAIL exec_entered alu_op=%0d exp=1", alu_op); end
    #3 rst = 1'b0;
    #1;
    n_checks++; if ({imem_req, wr_en, pc_inc, wr_sel, alu_op, src_reg, dst_reg, wr_reg, pc_data_in} !== 36'b0) begin n_fail++; $display("FAIL async_clear got=%h exp=0", {imem_req, wr_en, pc_inc, wr_sel, alu_op, src_reg, dst_reg, wr_reg, pc_data_in}); end
    for (int i = 0; i < 3; i++) begin
      step();
      if (wr_en !== 1'b0 || pc_inc !== 1'b0) strobe_seen++;
    end
    rst = 1'b1;
    step();
    if (wr_en !== 1'b0 || pc_inc !== 1'b0) strobe_seen++;
    n_checks++; if (strobe_seen !== 0 || imem_req !== 1'b1) begin n_fail++; $display("FAIL abandon_restart strobes=%0d req=%b exp=0,1", strobe_seen, imem_req); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_fetch_wait();
    test_jumps();
    test_mov_and_wrap();
    test_halt();
    test_reset_in_exec();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
